// File: rtl/imem_axi_read_master.sv
// Instruction-fetch AXI read master: IDLE/ADDR/DATA/DONE with one read outstanding.
// Define IMEM_PREFETCH_BUF_EN to add a 4-word line buffer filled by INCR bursts of 4.
module imem_axi_read_master #(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_err,
   output logic [3:0]  M_ARID,
   output logic [31:0] M_ARADDR,
   output logic [3:0]  M_ARLEN,
   output logic [2:0]  M_ARSIZE,
   output logic [1:0]  M_ARBURST,
   output logic        M_ARVALID,
   input  logic        M_ARREADY,
   input  logic [3:0]  M_RID,
   input  logic [31:0] M_RDATA,
   input  logic [1:0]  M_RRESP,
   input  logic        M_RLAST,
   input  logic        M_RVALID,
   output logic        M_RREADY
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t      state;
   logic [31:0] rdata_reg;
   logic [1:0]  beat_cnt;
   logic        err_flag;
   logic        hit;
   logic        beat;
   logic        beat_err;
   logic [31:0] hit_word;
   logic [31:0] fill_addr;
   logic [3:0]  fill_len;
   logic [1:0]  req_word;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];

   assign M_ARID    = MASTER_ID;
   assign M_ARSIZE  = 3'b010;
   assign M_ARBURST = 2'b01;

   // M_RREADY is high for the whole DATA state, so any RVALID there is a beat.
   assign beat      = (state == DATA) && M_RVALID;
   assign cpu_stall = cpu_req && (state != DONE) && !hit;
   assign cpu_rdata = hit ? hit_word : rdata_reg;

`ifdef IMEM_PREFETCH_BUF_EN
   logic [31:0] line_mem [4];
   logic [27:0] tag_reg;
   logic        valid_reg;
   logic [1:0]  word_reg;

   assign hit       = (state == IDLE) && cpu_req && valid_reg && (tag_reg == cpu_addr[31:4]);
   assign hit_word  = line_mem[cpu_addr[3:2]];
   assign fill_addr = {cpu_addr[31:4], 4'b0000};
   assign fill_len  = 4'd3;
   assign req_word  = word_reg;
   // A well-formed line fill ends exactly on its fourth beat.
   assign beat_err  = (M_RRESP != 2'b00) || (M_RID != MASTER_ID) ||
                      (M_RLAST != (beat_cnt == 2'd3));

   always_ff @(posedge ACLK) begin
      if (beat)
         line_mem[beat_cnt] <= M_RDATA;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         valid_reg <= 1'b0;
         tag_reg   <= '0;
         word_reg  <= '0;
      end else if ((state == IDLE) && cpu_req && !hit) begin
         valid_reg <= 1'b0;
         word_reg  <= cpu_addr[3:2];
      end else if (beat && M_RLAST) begin
         valid_reg <= !(err_flag || beat_err);
         tag_reg   <= M_ARADDR[31:4];
      end
   end
`else
   assign hit       = 1'b0;
   assign hit_word  = rdata_reg;
   assign fill_addr = {cpu_addr[31:2], 2'b00};
   assign fill_len  = 4'd0;
   assign req_word  = 2'd0;
   assign beat_err  = (M_RRESP != 2'b00) || (M_RID != MASTER_ID);
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state     <= IDLE;
         M_ARVALID <= 1'b0;
         M_ARADDR  <= '0;
         M_ARLEN   <= '0;
         M_RREADY  <= 1'b0;
         cpu_err   <= 1'b0;
         rdata_reg <= '0;
         err_flag  <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  rdata_reg <= hit_word;
               end else if (cpu_req) begin
                  M_ARADDR  <= fill_addr;
                  M_ARLEN   <= fill_len;
                  M_ARVALID <= 1'b1;
                  beat_cnt  <= '0;
                  err_flag  <= 1'b0;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (M_ARREADY) begin
                  M_ARVALID <= 1'b0;
                  M_RREADY  <= 1'b1;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (M_RVALID) begin
                  beat_cnt <= beat_cnt + 2'd1;
                  if (beat_cnt == req_word)
                     rdata_reg <= M_RDATA;
                  if (beat_err)
                     err_flag <= 1'b1;
                  if (M_RLAST) begin
                     M_RREADY <= 1'b0;
                     cpu_err  <= err_flag || beat_err;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               cpu_err  <= 1'b0;
               err_flag <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_axi_read_master.sv
// Randomized bench for imem_axi_read_master: a fetch-level memory and line-buffer model
// predicts data, errors, hits and AR contents; follows IMEM_PREFETCH_BUF_EN like the design.
module tb_imem_axi_read_master;
   localparam logic [3:0] TB_ID = 4'h5;
`ifdef IMEM_PREFETCH_BUF_EN
   localparam int LAT_MISS      = 6;
   localparam int LAT_SAME_LINE = 0;
`else
   localparam int LAT_MISS      = 3;
   localparam int LAT_SAME_LINE = 3;
`endif

   logic        ACLK;
   logic        ARESETn;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_err;
   logic [3:0]  M_ARID;
   logic [31:0] M_ARADDR;
   logic [3:0]  M_ARLEN;
   logic [2:0]  M_ARSIZE;
   logic [1:0]  M_ARBURST;
   logic        M_ARVALID;
   logic        M_ARREADY;
   logic [3:0]  M_RID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST;
   logic        M_RVALID;
   logic        M_RREADY;

   int n_tests;
   int n_fail;

   // fetch-level model state
   bit          buf_valid;
   logic [27:0] buf_tag;
   logic [31:0] last_rdata;
   bit          last_known;

   imem_axi_read_master #(.MASTER_ID(TB_ID)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .cpu_err(cpu_err),
      .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
      .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0000_0104)
         return 32'hDEAD_BEEF;
      return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   // err_kind: 0 clean, 1 bad RRESP, 2 bad RID, 3 early RLAST, 4 missing RLAST on 4th beat.
   // exp_lat < 0 skips the latency comparison.
   task automatic fetch(input logic [31:0] addr, input int ar_delay, input int gap_pct,
                        input int err_kind, input int err_beat_in, input bit scramble,
                        input int exp_lat);
      logic [31:0] exp_araddr, got_araddr, first_araddr;
      logic [3:0]  exp_arlen, got_arlen;
      logic [8:0]  got_ar_misc;
      int          nbeats, last_beat, err_beat, cyc, ar_wait, beat_idx;
      bit          exp_hit, exp_err, ar_done, ar_seen, ar_stable, junk_taken, done;
      bit          ar_hs, r_hs, junk, arv_s;
`ifdef IMEM_PREFETCH_BUF_EN
      exp_hit    = buf_valid && (buf_tag == addr[31:4]);
      exp_araddr = {addr[31:4], 4'h0};
      exp_arlen  = 4'd3;
      nbeats     = 4;
`else
      exp_hit    = 1'b0;
      exp_araddr = {addr[31:2], 2'b00};
      exp_arlen  = 4'd0;
      nbeats     = 1;
`endif
      err_beat  = (err_beat_in >= 0) ? (err_beat_in % nbeats) : int'($urandom_range(0, nbeats - 1));
      last_beat = nbeats - 1;
      if (err_kind == 3) begin
         if (err_beat > nbeats - 2) err_beat = nbeats - 2;
         last_beat = err_beat;
      end else if (err_kind == 4) begin
         last_beat = nbeats;
      end
      exp_err = !exp_hit && (err_kind != 0);

      cpu_req = 1'b1;
      cpu_addr = addr;
      ar_done = 0; ar_seen = 0; ar_stable = 1; junk_taken = 0; done = 0;
      cyc = 0; ar_wait = 0; beat_idx = 0;
      got_araddr = '0; got_arlen = '0; got_ar_misc = '0; first_araddr = '0;
      while (!done && cyc < 300) begin
         if (scramble && cyc > 0) cpu_addr = $urandom;
         if (!ar_done && M_ARVALID) M_ARREADY = (ar_wait >= ar_delay);
         else M_ARREADY = 1'($urandom_range(0, 1));
         junk = 1'b0;
         if (ar_done && beat_idx <= last_beat) begin
            M_RVALID = (int'($urandom_range(0, 99)) >= gap_pct);
            M_RDATA  = mem_word(exp_araddr + 32'(4 * beat_idx));
            M_RLAST  = (beat_idx == last_beat);
            M_RRESP  = (err_kind == 1 && beat_idx == err_beat) ? 2'($urandom_range(2, 3)) : 2'b00;
            M_RID    = (err_kind == 2 && beat_idx == err_beat) ? (TB_ID ^ 4'($urandom_range(1, 15))) : TB_ID;
         end else begin
            junk     = 1'($urandom_range(0, 1));
            M_RVALID = junk;
            M_RDATA  = $urandom;
            M_RLAST  = 1'($urandom_range(0, 1));
            M_RRESP  = 2'($urandom_range(0, 3));
            M_RID    = 4'($urandom_range(0, 15));
         end
         #1;
         arv_s = M_ARVALID;
         if (M_ARVALID) begin
            if (!ar_seen) first_araddr = M_ARADDR;
            else if (M_ARADDR != first_araddr) ar_stable = 1'b0;
            ar_seen = 1'b1;
         end
         ar_hs = M_ARVALID && M_ARREADY;
         r_hs  = M_RVALID && M_RREADY;
         if (ar_hs) begin
            got_araddr  = M_ARADDR;
            got_arlen   = M_ARLEN;
            got_ar_misc = {M_ARID, M_ARSIZE, M_ARBURST};
         end
         if (r_hs && junk) junk_taken = 1'b1;
         if (!cpu_stall) begin
            done = 1'b1;
            check_eq("fetch_err", cpu_err, exp_err);
            if (!exp_err) check_eq("fetch_data", cpu_rdata, mem_word(addr));
            if (exp_lat >= 0) check_eq("fetch_latency", cyc, exp_lat);
         end
         @(posedge ACLK);
         if (ar_hs) ar_done = 1'b1;
         else if (arv_s && !ar_done) ar_wait++;
         if (r_hs && !junk) beat_idx++;
         @(negedge ACLK);
         cyc++;
      end
      check_eq("fetch_done", done, 1'b1);
      check_eq("ar_issued", ar_seen, !exp_hit);
      if (!exp_hit) begin
         check_eq("ar_fields", {got_araddr, got_arlen, got_ar_misc},
                  {exp_araddr, exp_arlen, TB_ID, 3'b010, 2'b01});
         check_eq("ar_stable", ar_stable, 1'b1);
      end
      check_eq("rready_outside_data", junk_taken, 1'b0);
      check_eq("err_pulse_clear", cpu_err, 1'b0);
      $display("[TB] fetch addr=%08h hit=%0d err_kind=%0d exp_err=%0d cycles=%0d", addr, exp_hit, err_kind, exp_err, cyc);

`ifdef IMEM_PREFETCH_BUF_EN
      if (!exp_hit) begin
         buf_valid = !exp_err;
         buf_tag   = addr[31:4];
      end
`endif
      if (!exp_err) begin
         last_rdata = mem_word(addr);
         last_known = 1'b1;
      end else begin
         last_known = 1'b0;
      end
   endtask

   // No request: stray R/AR activity must be ignored and cpu_rdata held.
   task automatic idle_gap(input int n);
      cpu_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         cpu_addr  = $urandom;
         M_RVALID  = 1'($urandom_range(0, 1));
         M_RDATA   = $urandom;
         M_RLAST   = 1'($urandom_range(0, 1));
         M_RRESP   = 2'($urandom_range(0, 3));
         M_RID     = TB_ID;
         M_ARREADY = 1'($urandom_range(0, 1));
         #1;
         check_eq("idle_bus", {M_RREADY, M_ARVALID, cpu_stall}, 3'b000);
         @(posedge ACLK);
         @(negedge ACLK);
      end
      if (last_known) check_eq("idle_hold_rdata", cpu_rdata, last_rdata);
      $display("[TB] idle gap of %0d cycles", n);
   endtask

   task automatic reset_mid_burst(input logic [31:0] addr);
      int guard;
      cpu_req = 1'b1; cpu_addr = addr;
      M_ARREADY = 1'b1; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00; M_RID = TB_ID;
      guard = 0;
      while (!M_RREADY && guard < 20) begin
         @(posedge ACLK);
         @(negedge ACLK);
         guard++;
      end
      check_eq("rst_reach_data", M_RREADY, 1'b1);
`ifdef IMEM_PREFETCH_BUF_EN
      M_RVALID = 1'b1;
      M_RDATA  = mem_word({addr[31:4], 4'h0});
      M_RLAST  = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
`else
      M_RLAST  = 1'b1;
`endif
      M_RVALID = 1'b1;
      M_RDATA  = 32'h1234_5678;
      #1 ARESETn = 1'b0;
      #1;
      check_eq("rst_outputs",
               {M_ARVALID, M_RREADY, cpu_err, cpu_rdata, M_ARID, M_ARADDR, M_ARLEN, cpu_stall},
               {1'b0, 1'b0, 1'b0, 32'h0, TB_ID, 32'h0, 4'h0, 1'b1});
      @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      cpu_req = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      check_eq("rst_no_capture", {M_RREADY, M_ARVALID, cpu_rdata}, {1'b0, 1'b0, 32'h0});
      M_RVALID = 1'b0;
      buf_valid  = 1'b0;
      last_rdata = 32'h0;
      last_known = 1'b1;
      $display("[TB] reset asserted mid-burst at addr=%08h", addr);
   endtask

   initial begin
      logic [31:0] a;
      int          kind;
      n_tests = 0; n_fail = 0;
      buf_valid = 1'b0; buf_tag = '0; last_rdata = '0; last_known = 1'b1;
      ARESETn = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
      M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; M_RLAST = 1'b0; M_RID = '0;
      @(negedge ACLK);
      #1;
      check_eq("reset_state",
               {M_ARVALID, M_RREADY, cpu_err, cpu_rdata, M_ARID, M_ARADDR, M_ARLEN, cpu_stall},
               {1'b0, 1'b0, 1'b0, 32'h0, TB_ID, 32'h0, 4'h0, 1'b0});
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);

      fetch(32'h0000_0104, 0, 0, 0, -1, 1'b0, LAT_MISS);
      idle_gap(2);
      fetch(32'h0000_3000, 5, 0, 0, -1, 1'b0, LAT_MISS + 5);
      fetch(32'h0000_0208, 0, 0, 0, -1, 1'b0, LAT_MISS);
      fetch(32'h0000_020C, 0, 0, 0, -1, 1'b0, LAT_SAME_LINE);
      fetch(32'h0000_0400, 0, 0, 1, 1, 1'b0, LAT_MISS);
      fetch(32'h0000_0404, 0, 0, 0, -1, 1'b0, LAT_MISS);
      idle_gap(6);
      fetch(32'h0000_0408, 0, 0, 0, -1, 1'b0, LAT_SAME_LINE);
      fetch(32'h0000_0500, 2, 30, 0, -1, 1'b1, -1);
      reset_mid_burst(32'h0000_0600);
      idle_gap(2);
      fetch(32'h0000_0604, 0, 0, 0, -1, 1'b0, LAT_MISS);

      for (int i = 0; i < 200; i++) begin
         a = 32'h0000_1000 + 32'($urandom_range(0, 255));
         kind = 0;
         if ($urandom_range(0, 99) < 25) begin
`ifdef IMEM_PREFETCH_BUF_EN
            kind = int'($urandom_range(1, 4));
`else
            kind = int'($urandom_range(1, 2));
`endif
         end
         fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), kind, -1,
               ($urandom_range(0, 3) == 0), -1);
         if ($urandom_range(0, 2) == 0) idle_gap(int'($urandom_range(1, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_axi_read_master.md
IMEM_AXI_READ_MASTER -- requirements
Module: imem_axi_read_master

Interface
REQ-001 Parameter MASTER_ID, default 4'd0, value driven on M_ARID for every request.
REQ-002 ACLK  input  1  clock; all state updates on rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU instruction-fetch request, held high with cpu_addr stable until cpu_stall is low.
REQ-005 cpu_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 cpu_rdata  output  32  fetched instruction word, valid when cpu_req=1 and cpu_stall=0.
REQ-007 cpu_stall  output  1  high while the requested word is not yet available.
REQ-008 cpu_err  output  1  one-cycle pulse marking the completing fetch as failed.
REQ-009 M_ARID  output  4, M_ARADDR  output  32, M_ARLEN  output  4, M_ARSIZE  output  3, M_ARBURST  output  2, M_ARVALID  output  1, M_ARREADY  input  1  AXI read-address channel.
REQ-010 M_RID  input  4, M_RDATA  input  32, M_RRESP  input  2, M_RLAST  input  1, M_RVALID  input  1, M_RREADY  output  1  AXI read-data channel.

Function
REQ-011 The FSM SHALL have states IDLE, ADDR, DATA, DONE; at most one AXI transaction outstanding.
REQ-012 IDLE: cpu_req=1 and no buffer hit -> latch address, go to ADDR next cycle; otherwise stay in IDLE.
REQ-013 ADDR: M_ARVALID=1; M_ARADDR/M_ARLEN/M_ARSIZE/M_ARBURST held stable until M_ARVALID&M_ARREADY, then go to DATA.
REQ-014 M_ARSIZE SHALL be 3'b010 (4 bytes) and M_ARBURST 2'b01 (INCR) for every request.
REQ-015 DATA: M_RREADY=1; each beat with M_RVALID=1 is accepted; the beat with M_RLAST=1 moves the FSM to DONE.
REQ-016 DONE: cpu_stall=0, cpu_rdata = captured requested word; next state IDLE.
REQ-017 cpu_stall SHALL be combinational: 1 when cpu_req=1 and the FSM is not in DONE and there is no buffer hit; 0 otherwise (including cpu_req=0).
REQ-018 Minimum miss latency with M_ARREADY and M_RVALID always high: request at cycle 0, ARVALID at cycle 1, data beat(s) from cycle 2, cpu_stall low in the cycle after the RLAST beat.
REQ-019 Any accepted beat with M_RRESP != 2'b00 or M_RID != MASTER_ID SHALL set a sticky error flag; cpu_err=1 in DONE if set; flag cleared on DONE exit.
REQ-020 cpu_addr changes after latching SHALL be ignored until DONE; the latched address alone drives M_ARADDR and word selection.
REQ-021 M_RVALID outside DATA SHALL be ignored (M_RREADY=0); M_ARREADY outside ADDR SHALL be ignored.
REQ-022 cpu_rdata SHALL hold its last value when not in DONE and not on a hit.

Reset
REQ-023 ARESETn low SHALL force: state IDLE, M_ARVALID=0, M_RREADY=0, cpu_err=0, cpu_rdata=0, error flag cleared, buffer invalid, beat counter 0; M_ARID=MASTER_ID, M_ARADDR=0, M_ARLEN=0.
REQ-024 Reset mid-transaction SHALL abandon the burst; no pending beat is captured after release.

Configuration
REQ-025 Macro IMEM_PREFETCH_BUF_EN defined: 4-word line buffer with 28-bit tag and valid bit; miss issues M_ARADDR={addr[31:4],4'b0}, M_ARLEN=4'd3; 2-bit beat counter writes beat n to word n; requested word addr[3:2] returned in DONE; hit (valid and tag==cpu_addr[31:4] in IDLE) gives cpu_stall=0 and cpu_rdata=buffer[addr[3:2]] same cycle, no AXI traffic.
REQ-026 With IMEM_PREFETCH_BUF_EN: RLAST before the 4th beat or no RLAST on the 4th beat SHALL set the error flag; any error leaves the buffer invalid; clean completion sets valid.
REQ-027 Macro undefined: no buffer, no hits; M_ARADDR={addr[31:2],2'b00}, M_ARLEN=4'd0; the single beat is returned.

Verification
REQ-028 No macro, cpu_addr=0x0000_0104, ARREADY/RVALID always 1, RDATA=0xDEAD_BEEF -> ARADDR=0x104, ARLEN=0, cpu_rdata=0xDEADBEEF with cpu_stall low at cycle 3.
REQ-029 ARREADY delayed 5 cycles -> ARVALID held 6 cycles with ARADDR constant; cpu_stall high throughout.
REQ-030 Macro defined, fetch 0x0000_0208 then 0x0000_020C -> one burst ARADDR=0x200, ARLEN=3; second fetch hits, cpu_stall=0 same cycle, no ARVALID.
REQ-031 RRESP=2'b10 on beat 1 of a burst -> cpu_err=1 in DONE; repeat fetch to same line misses and re-issues AR.
REQ-032 ARESETn low during beat 2 of a burst -> outputs per REQ-023; next fetch to same line issues a new AR.
REQ-033 RVALID=1 while in IDLE with cpu_req=0 -> RREADY stays 0, cpu_rdata and buffer unchanged.
